ysyx_22050710_lsu_ctrl: RTL and testbench
=========================================

YSYX_22050710_LSU_CTRL -- requirements
Module: ysyx_22050710_lsu_ctrl

Interface
REQ-001 SHALL have parameter ADDR_WD, default 64, meaning byte address width.
REQ-002 SHALL have parameter WORD_WD, default 64, meaning store-data width.
REQ-003 SHALL have parameter SRAM_DATA_WD, default 64, meaning data SRAM beat width.
REQ-004 SHALL have port i_clk, input, 1, meaning the single clock; all state changes on its rising edge.
REQ-005 SHALL have port i_rst, input, 1, meaning the reset; it is synchronous and active-high.
REQ-006 SHALL have port i_mem_valid, input, 1, meaning the MEM stage holds a valid instruction.
REQ-007 SHALL have ports i_mem_ren and i_mem_wen, input, 1 each, meaning load and store request.
REQ-008 SHALL have port i_mem_op, input, 3, meaning size code: 000/001 byte, 010/011 half, 100/101 word, 110 double.
REQ-009 SHALL have ports i_mem_addr, input, ADDR_WD, and i_mem_wdata, input, WORD_WD, meaning byte address and store data.
REQ-010 SHALL have port o_stall, output, 1, meaning hold the pipeline.
REQ-011 SHALL have ports o_sram_req_valid, output, 1, and i_sram_req_ready, input, 1, meaning the request handshake.
REQ-012 SHALL have ports o_sram_addr, output, ADDR_WD, o_sram_wen, output, 1, o_sram_wdata, output, SRAM_DATA_WD, and o_sram_wmask, output, 8, meaning request payload.
REQ-013 SHALL have ports i_sram_rvalid, input, 1, i_sram_rdata, input, SRAM_DATA_WD, and i_sram_bvalid, input, 1, meaning read and write responses.
REQ-014 SHALL have ports o_raddr_align, output, 3, o_data_sram_rdata, output, SRAM_DATA_WD, and o_mem_ren, output, 1, meaning the load-extract stage feed.

Function
REQ-015 SHALL implement FSM states IDLE, REQ, WAIT_R, WAIT_B and DONE.
REQ-016 In IDLE with i_mem_valid and (i_mem_ren or i_mem_wen), SHALL register addr, op, wdata and the type, then enter REQ.
REQ-017 If both ren and wen are set, SHALL perform the store only.
REQ-018 In REQ, SHALL drive o_sram_req_valid=1 and hold the payload stable until i_sram_req_ready=1.
REQ-019 On the request handshake, SHALL enter WAIT_R for a load or WAIT_B for a store.
REQ-020 o_sram_addr SHALL equal the latched address with bits [2:0] cleared.
REQ-021 For a store, o_sram_wdata SHALL equal wdata shifted left by 8*addr[2:0], zero-filled.
REQ-022 For a store, o_sram_wmask SHALL equal the size mask (0x01, 0x03, 0x0F, 0xFF) shifted left by addr[2:0], truncated to 8 bits; no misalignment error is raised.
REQ-023 For a load, o_sram_wen and o_sram_wmask SHALL be 0.
REQ-024 SHALL ignore i_sram_rvalid and i_sram_bvalid outside WAIT_R and WAIT_B respectively; the SRAM never responds in the handshake cycle.
REQ-025 In WAIT_R on i_sram_rvalid, SHALL register i_sram_rdata into o_data_sram_rdata and addr[2:0] into o_raddr_align, then enter DONE.
REQ-026 In WAIT_B on i_sram_bvalid, SHALL enter DONE.
REQ-027 DONE SHALL last exactly one cycle, then return to IDLE; DONE SHALL not accept a new request.
REQ-028 o_mem_ren SHALL be 1 only in DONE of a load.
REQ-029 o_data_sram_rdata and o_raddr_align SHALL hold their values until the next load completes.
REQ-030 o_stall SHALL be 1 in REQ, WAIT_R and WAIT_B, and combinationally in IDLE when a request is presented; otherwise 0.
REQ-031 Minimum load latency SHALL be 4 cycles (accept, REQ handshake, response, DONE) with zero-wait SRAM.
REQ-032 With i_mem_valid=0 or no ren/wen, SHALL stay in IDLE with o_stall=0 and o_sram_req_valid=0.

Reset
REQ-033 i_rst SHALL force IDLE on the next edge, from any state including mid-transaction.
REQ-034 Reset SHALL zero o_sram_req_valid, o_sram_wen, o_sram_wmask, o_sram_addr, o_sram_wdata, o_data_sram_rdata, o_raddr_align and o_mem_ren; o_stall SHALL then follow REQ-030.
REQ-035 A response arriving after reset SHALL be ignored.

Verification
REQ-036 Load, addr=0x8000_0003, op=000, ready=1, rdata=0x1122334455667788 next cycle -> o_sram_addr=0x8000_0000; DONE cycle has o_mem_ren=1, o_raddr_align=3, o_data_sram_rdata=0x1122334455667788.
REQ-037 Store, addr=0x8000_0006, op=010, wdata=0xABCD -> wmask=0xC0, wdata=0xABCD_0000_0000_0000, wen=1; DONE one cycle after bvalid.
REQ-038 Load with req_ready held low 3 cycles -> payload stable, o_stall=1 throughout, exactly one handshake.
REQ-039 Reset asserted in WAIT_R, then rvalid=1 -> IDLE, o_data_sram_rdata=0, o_mem_ren never asserts.
REQ-040 Back-to-back: store then load with valid held -> second request accepted only in the IDLE cycle after DONE; no overlap of request handshakes.

Source files
------------

// File: rtl/ysyx_22050710_lsu_ctrl_if.sv
// Pipeline-side and data-SRAM-side signals of the LSU controller, bundled so the
// controller and its environment share one declaration.
interface ysyx_22050710_lsu_ctrl_if #(
   parameter int ADDR_WD      = 64,
   parameter int WORD_WD      = 64,
   parameter int SRAM_DATA_WD = 64
);
   logic                    i_mem_valid;
   logic                    i_mem_ren;
   logic                    i_mem_wen;
   logic [2:0]              i_mem_op;
   logic [ADDR_WD-1:0]      i_mem_addr;
   logic [WORD_WD-1:0]      i_mem_wdata;
   logic                    o_stall;

   logic                    o_sram_req_valid;
   logic                    i_sram_req_ready;
   logic [ADDR_WD-1:0]      o_sram_addr;
   logic                    o_sram_wen;
   logic [SRAM_DATA_WD-1:0] o_sram_wdata;
   logic [7:0]              o_sram_wmask;
   logic                    i_sram_rvalid;
   logic [SRAM_DATA_WD-1:0] i_sram_rdata;
   logic                    i_sram_bvalid;

   logic [2:0]              o_raddr_align;
   logic [SRAM_DATA_WD-1:0] o_data_sram_rdata;
   logic                    o_mem_ren;

   // The controller masters the SRAM request bus.
   modport master (
      input  i_mem_valid, i_mem_ren, i_mem_wen, i_mem_op, i_mem_addr, i_mem_wdata,
      output o_stall,
      output o_sram_req_valid, o_sram_addr, o_sram_wen, o_sram_wdata, o_sram_wmask,
      input  i_sram_req_ready, i_sram_rvalid, i_sram_rdata, i_sram_bvalid,
      output o_raddr_align, o_data_sram_rdata, o_mem_ren
   );

   modport slave (
      output i_mem_valid, i_mem_ren, i_mem_wen, i_mem_op, i_mem_addr, i_mem_wdata,
      input  o_stall,
      input  o_sram_req_valid, o_sram_addr, o_sram_wen, o_sram_wdata, o_sram_wmask,
      output i_sram_req_ready, i_sram_rvalid, i_sram_rdata, i_sram_bvalid,
      input  o_raddr_align, o_data_sram_rdata, o_mem_ren
   );
endinterface

// File: rtl/ysyx_22050710_lsu_ctrl.sv
// MEM-stage load/store controller: turns one pipeline memory access into a single
// aligned data-SRAM transaction and stalls the pipeline until it completes.
module ysyx_22050710_lsu_ctrl #(
   parameter int ADDR_WD      = 64,
   parameter int WORD_WD      = 64,
   parameter int SRAM_DATA_WD = 64
) (
   input logic                     i_clk,
   input logic                     i_rst,
   ysyx_22050710_lsu_ctrl_if.master bus
);

   typedef enum logic [2:0] {IDLE, REQ, WAIT_R, WAIT_B, DONE} state_e;

   state_e                  state;
   state_e                  state_nxt;
   logic [ADDR_WD-1:0]      addr_q;
   logic [1:0]              size_q;
   logic [WORD_WD-1:0]      wdata_q;
   logic                    store_q;
   logic [SRAM_DATA_WD-1:0] rdata_q;
   logic [2:0]              align_q;

   logic                    req_in;
   logic                    accept;
   logic                    load_done;
   logic [7:0]              size_mask;
   logic [SRAM_DATA_WD-1:0] wdata_ext;
   logic                    unused_op_lsb;

   // op[0] only selects sign extension, which happens downstream.
   assign unused_op_lsb = bus.i_mem_op[0];

   assign req_in    = bus.i_mem_valid & (bus.i_mem_ren | bus.i_mem_wen);
   assign accept    = (state == IDLE) & req_in;
   assign load_done = (state == WAIT_R) & bus.i_sram_rvalid;

   always_ff @(posedge i_clk) begin
      // NOTE: all state updates here are non-blocking so every register samples pre-edge values.
      if (i_rst) begin
         state   <= IDLE;
         addr_q  <= '0;
         size_q  <= '0;
         wdata_q <= '0;
         store_q <= 1'b0;
         rdata_q <= '0;
         align_q <= '0;
      end else begin
         state <= state_nxt;
         if (accept) begin
            addr_q  <= bus.i_mem_addr;
            size_q  <= bus.i_mem_op[2:1];
            wdata_q <= bus.i_mem_wdata;
            store_q <= bus.i_mem_wen;  // a store wins when both ren and wen are set
         end
         if (load_done) begin
            rdata_q <= bus.i_sram_rdata;
            align_q <= addr_q[2:0];
         end
      end
   end

   always_comb begin
      // NOTE: next state defaults to the current one so no branch leaves it unassigned (no latch).
      state_nxt = state;
      unique case (state)
         IDLE:    if (req_in)               state_nxt = REQ;
         REQ:     if (bus.i_sram_req_ready) state_nxt = store_q ? WAIT_B : WAIT_R;
         WAIT_R:  if (bus.i_sram_rvalid)    state_nxt = DONE;
         WAIT_B:  if (bus.i_sram_bvalid)    state_nxt = DONE;
         DONE:                              state_nxt = IDLE;
         default:                           state_nxt = IDLE;
      endcase
   end

   always_comb begin
      size_mask = 8'h01;
      unique case (size_q)
         2'b00: size_mask = 8'h01;
         2'b01: size_mask = 8'h03;
         2'b10: size_mask = 8'h0F;
         2'b11: size_mask = 8'hFF;
         default: size_mask = 8'h01;
      endcase
   end

   assign wdata_ext = SRAM_DATA_WD'(wdata_q);

   // Payload comes straight from the latched request, so it is stable while REQ waits.
   assign bus.o_sram_req_valid = (state == REQ);
   assign bus.o_sram_addr      = {addr_q[ADDR_WD-1:3], 3'b000};
   assign bus.o_sram_wen       = store_q;
   assign bus.o_sram_wdata     = store_q ? (wdata_ext << {addr_q[2:0], 3'b000}) : '0;
   assign bus.o_sram_wmask     = store_q ? (size_mask << addr_q[2:0]) : 8'h00;

   assign bus.o_stall = (state == REQ) | (state == WAIT_R) | (state == WAIT_B) | accept;

   assign bus.o_mem_ren         = (state == DONE) & ~store_q;
   assign bus.o_data_sram_rdata = rdata_q;
   assign bus.o_raddr_align     = align_q;

endmodule

// File: tb/tb_ysyx_22050710_lsu_ctrl.sv
// Scoreboard bench for the LSU controller: directed vectors push expected SRAM
// requests and load completions; a negedge monitor pops and compares them.
module tb_ysyx_22050710_lsu_ctrl;

   typedef enum logic [1:0] {K_NONE, K_REQ, K_LDONE} kind_e;

   typedef struct {
      kind_e       kind;
      logic [63:0] addr;
      logic        wen;
      logic [63:0] wdata;
      logic [7:0]  wmask;
      logic [63:0] rdata;
      logic [2:0]  align;
   } exp_t;

   typedef struct {
      logic        ren;
      logic        wen;
      logic [2:0]  op;
      logic [63:0] addr;
      logic [63:0] wdata;
      logic [63:0] rdata;
      int          rdy_dly;
      int          rsp_dly;
      logic [63:0] exp_addr;
      logic [63:0] exp_wdata;
      logic [7:0]  exp_wmask;
      logic [2:0]  exp_align;
   } vec_t;

   logic clk = 1'b0;
   logic rst = 1'b1;

   int   n_checks = 0;
   int   n_err    = 0;
   int   hs_count = 0;
   int   hs_expected = 0;
   exp_t exp_q[$];
   exp_t mon_e;
   kind_e mon_k;

   logic [63:0] last_rdata = '0;
   logic [2:0]  last_align = '0;
   vec_t        vecs[6];

   ysyx_22050710_lsu_ctrl_if #(.ADDR_WD(64), .WORD_WD(64), .SRAM_DATA_WD(64)) bus ();

   ysyx_22050710_lsu_ctrl #(.ADDR_WD(64), .WORD_WD(64), .SRAM_DATA_WD(64)) dut (
      .i_clk (clk),
      .i_rst (rst),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] expv);
      n_checks++;
      if (act !== expv) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, expv, $time);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #2;
   endtask

   task automatic push_req(input logic [63:0] a, input logic w, input logic [63:0] d,
                           input logic [7:0] m);
      exp_t e;
      e = '{kind: K_REQ, addr: a, wen: w, wdata: d, wmask: m, rdata: '0, align: '0};
      exp_q.push_back(e);
      hs_expected++;
   endtask

   task automatic push_ldone(input logic [63:0] r, input logic [2:0] al);
      exp_t e;
      e = '{kind: K_LDONE, addr: '0, wen: 1'b0, wdata: '0, wmask: '0, rdata: r, align: al};
      exp_q.push_back(e);
   endtask

   task automatic drive_idle();
      bus.i_mem_valid = 1'b0;
      bus.i_mem_ren   = 1'b0;
      bus.i_mem_wen   = 1'b0;
   endtask

   // Scoreboard monitor: every handshake and every load completion must be expected.
   always @(negedge clk) begin
      if (!rst) begin
         if (bus.o_sram_req_valid && bus.i_sram_req_ready) begin
            hs_count++;
            mon_k = (exp_q.size() != 0) ? exp_q[0].kind : K_NONE;
            check("hs_kind", 64'(mon_k), 64'(K_REQ));
            if (mon_k == K_REQ) begin
               mon_e = exp_q.pop_front();
               check("hs_addr",  bus.o_sram_addr, mon_e.addr);
               check("hs_wen",   64'(bus.o_sram_wen), 64'(mon_e.wen));
               check("hs_wdata", bus.o_sram_wdata, mon_e.wdata);
               check("hs_wmask", 64'(bus.o_sram_wmask), 64'(mon_e.wmask));
            end
         end
         if (bus.o_mem_ren) begin
            mon_k = (exp_q.size() != 0) ? exp_q[0].kind : K_NONE;
            check("ld_kind", 64'(mon_k), 64'(K_LDONE));
            if (mon_k == K_LDONE) begin
               mon_e = exp_q.pop_front();
               check("ld_rdata", bus.o_data_sram_rdata, mon_e.rdata);
               check("ld_align", 64'(bus.o_raddr_align), 64'(mon_e.align));
            end
         end
      end
   end

   task automatic run_vec(input vec_t v);
      step();
      bus.i_mem_valid      = 1'b1;
      bus.i_mem_ren        = v.ren;
      bus.i_mem_wen        = v.wen;
      bus.i_mem_op         = v.op;
      bus.i_mem_addr       = v.addr;
      bus.i_mem_wdata      = v.wdata;
      bus.i_sram_req_ready = (v.rdy_dly == 0);
      push_req(v.exp_addr, v.wen, v.exp_wdata, v.exp_wmask);
      if (!v.wen) push_ldone(v.rdata, v.exp_align);
      @(negedge clk);
      check("idle_stall", 64'(bus.o_stall), 64'd1);
      check("idle_reqv",  64'(bus.o_sram_req_valid), 64'd0);
      step();
      drive_idle();
      for (int i = 0; i < v.rdy_dly; i++) begin
         @(negedge clk);
         check("req_stall", 64'(bus.o_stall), 64'd1);
         check("req_valid", 64'(bus.o_sram_req_valid), 64'd1);
         check("req_addr_stable",  bus.o_sram_addr, v.exp_addr);
         check("req_wmask_stable", 64'(bus.o_sram_wmask), 64'(v.exp_wmask));
         step();
         if (i == v.rdy_dly - 1) bus.i_sram_req_ready = 1'b1;
      end
      @(negedge clk);
      check("hs_stall", 64'(bus.o_stall), 64'd1);
      step();
      bus.i_sram_req_ready = 1'b0;
      for (int i = 0; i < v.rsp_dly; i++) begin
         @(negedge clk);
         check("wait_stall", 64'(bus.o_stall), 64'd1);
         check("wait_reqv",  64'(bus.o_sram_req_valid), 64'd0);
         step();
      end
      bus.i_sram_rvalid = !v.wen;
      bus.i_sram_bvalid = v.wen;
      bus.i_sram_rdata  = v.rdata;
      step();
      bus.i_sram_rvalid = 1'b0;
      bus.i_sram_bvalid = 1'b0;
      bus.i_sram_rdata  = '0;
      @(negedge clk);
      check("done_stall",   64'(bus.o_stall), 64'd0);
      check("done_mem_ren", 64'(bus.o_mem_ren), 64'(!v.wen));
      step();
      if (!v.wen) begin
         last_rdata = v.rdata;
         last_align = v.exp_align;
      end
      @(negedge clk);
      check("after_stall",   64'(bus.o_stall), 64'd0);
      check("after_mem_ren", 64'(bus.o_mem_ren), 64'd0);
      check("held_rdata",    bus.o_data_sram_rdata, last_rdata);
      check("held_align",    64'(bus.o_raddr_align), 64'(last_align));
      check("hs_count",      64'(hs_count), 64'(hs_expected));
   endtask

   initial begin
      drive_idle();
      bus.i_mem_op         = '0;
      bus.i_mem_addr       = '0;
      bus.i_mem_wdata      = '0;
      bus.i_sram_req_ready = 1'b0;
      bus.i_sram_rvalid    = 1'b0;
      bus.i_sram_rdata     = '0;
      bus.i_sram_bvalid    = 1'b0;

      vecs[0] = '{1'b1, 1'b0, 3'b000, 64'h8000_0003, 64'h0, 64'h1122_3344_5566_7788, 0, 0,
                  64'h8000_0000, 64'h0, 8'h00, 3'd3};
      vecs[1] = '{1'b0, 1'b1, 3'b010, 64'h8000_0006, 64'hABCD, 64'h0, 0, 1,
                  64'h8000_0000, 64'hABCD_0000_0000_0000, 8'hC0, 3'd0};
      vecs[2] = '{1'b1, 1'b0, 3'b011, 64'h8000_1236, 64'h0, 64'hCAFE_BABE_DEAD_BEEF, 3, 2,
                  64'h8000_1230, 64'h0, 8'h00, 3'd6};
      vecs[3] = '{1'b1, 1'b1, 3'b110, 64'h10, 64'h0123_4567_89AB_CDEF, 64'h0, 0, 0,
                  64'h10, 64'h0123_4567_89AB_CDEF, 8'hFF, 3'd0};
      vecs[4] = '{1'b0, 1'b1, 3'b101, 64'h1005, 64'h1122_3344, 64'h0, 1, 0,
                  64'h1000, 64'h2233_4400_0000_0000, 8'hE0, 3'd0};
      vecs[5] = '{1'b0, 1'b1, 3'b001, 64'h7, 64'h5A, 64'h0, 0, 0,
                  64'h0, 64'h5A00_0000_0000_0000, 8'h80, 3'd0};

      repeat (2) @(posedge clk);
      @(negedge clk);
      check("rst_reqv",  64'(bus.o_sram_req_valid), 64'd0);
      check("rst_wen",   64'(bus.o_sram_wen), 64'd0);
      check("rst_wmask", 64'(bus.o_sram_wmask), 64'd0);
      check("rst_addr",  bus.o_sram_addr, 64'd0);
      check("rst_wdata", bus.o_sram_wdata, 64'd0);
      check("rst_rdata", bus.o_data_sram_rdata, 64'd0);
      check("rst_align", 64'(bus.o_raddr_align), 64'd0);
      check("rst_mem_ren", 64'(bus.o_mem_ren), 64'd0);
      check("rst_stall", 64'(bus.o_stall), 64'd0);
      step();
      rst = 1'b0;

      foreach (vecs[i]) run_vec(vecs[i]);

      // No request without ren/wen, or without valid.
      step();
      bus.i_mem_valid = 1'b1;
      @(negedge clk);
      check("noop_stall", 64'(bus.o_stall), 64'd0);
      step();
      bus.i_mem_valid = 1'b0;
      bus.i_mem_ren   = 1'b1;
      @(negedge clk);
      check("noval_stall", 64'(bus.o_stall), 64'd0);
      check("noval_reqv",  64'(bus.o_sram_req_valid), 64'd0);
      step();
      drive_idle();

      // Reset while waiting for read data; the late response must be dropped.
      bus.i_mem_valid      = 1'b1;
      bus.i_mem_ren        = 1'b1;
      bus.i_mem_op         = 3'b100;
      bus.i_mem_addr       = 64'h2004;
      bus.i_sram_req_ready = 1'b1;
      push_req(64'h2000, 1'b0, 64'h0, 8'h00);
      step();
      drive_idle();
      step();
      bus.i_sram_req_ready = 1'b0;
      @(negedge clk);
      check("waitr_stall", 64'(bus.o_stall), 64'd1);
      step();
      rst = 1'b1;
      step();
      rst               = 1'b0;
      bus.i_sram_rvalid = 1'b1;
      bus.i_sram_rdata  = 64'hDEAD_BEEF_0BAD_F00D;
      step();
      bus.i_sram_rvalid = 1'b0;
      bus.i_sram_rdata  = '0;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         check("post_rst_stall",   64'(bus.o_stall), 64'd0);
         check("post_rst_reqv",    64'(bus.o_sram_req_valid), 64'd0);
         check("post_rst_mem_ren", 64'(bus.o_mem_ren), 64'd0);
         check("post_rst_rdata",   bus.o_data_sram_rdata, 64'd0);
         check("post_rst_align",   64'(bus.o_raddr_align), 64'd0);
         step();
      end

      // Back-to-back: store, then a load already presented during DONE.
      bus.i_mem_valid      = 1'b1;
      bus.i_mem_wen        = 1'b1;
      bus.i_mem_op         = 3'b110;
      bus.i_mem_addr       = 64'h3000;
      bus.i_mem_wdata      = 64'h55;
      bus.i_sram_req_ready = 1'b1;
      push_req(64'h3000, 1'b1, 64'h55, 8'hFF);
      step();
      step();
      bus.i_sram_req_ready = 1'b0;
      bus.i_sram_bvalid    = 1'b1;
      step();
      bus.i_sram_bvalid    = 1'b0;
      bus.i_mem_wen        = 1'b0;
      bus.i_mem_ren        = 1'b1;
      bus.i_mem_op         = 3'b100;
      bus.i_mem_addr       = 64'h3008;
      bus.i_sram_req_ready = 1'b1;
      push_req(64'h3008, 1'b0, 64'h0, 8'h00);
      push_ldone(64'h0A0B_0C0D_0E0F_1011, 3'd0);
      @(negedge clk);
      check("b2b_done_stall", 64'(bus.o_stall), 64'd0);
      check("b2b_done_reqv",  64'(bus.o_sram_req_valid), 64'd0);
      step();
      @(negedge clk);
      check("b2b_idle_stall", 64'(bus.o_stall), 64'd1);
      check("b2b_idle_reqv",  64'(bus.o_sram_req_valid), 64'd0);
      step();
      drive_idle();
      @(negedge clk);
      check("b2b_req_valid", 64'(bus.o_sram_req_valid), 64'd1);
      step();
      bus.i_sram_req_ready = 1'b0;
      bus.i_sram_rvalid    = 1'b1;
      bus.i_sram_rdata     = 64'h0A0B_0C0D_0E0F_1011;
      step();
      bus.i_sram_rvalid = 1'b0;
      bus.i_sram_rdata  = '0;
      @(negedge clk);
      check("b2b_mem_ren", 64'(bus.o_mem_ren), 64'd1);
      repeat (3) step();

      @(negedge clk);
      check("queue_empty", 64'(exp_q.size()), 64'd0);
      check("final_hs_count", 64'(hs_count), 64'(hs_expected));
      $display("Result: errors=%0d of %0d checks", n_err, n_checks);
      $finish;
   end

endmodule
